// File: rtl/pipe_reg_mw.sv
// MEM->WB pipeline register with load alignment,
// stall/flush handling and a retired-instruction counter.
module pipe_reg_mw #(
  parameter int W  = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stallW,
  input  logic          flushW,
  input  logic          validM,
  input  logic [W-1:0]  aluresultM,
  input  logic [W-1:0]  readdataM,
  input  logic [W-1:0]  pcplus4M,
  input  logic [W-1:0]  immextM,
  input  logic [2:0]    funct3M,
  input  logic [4:0]    rdM,
  input  logic          regwriteM,
  input  logic [1:0]    resultsrcM,
  output logic [W-1:0]  aluresultW,
  output logic [W-1:0]  readdataW,
  output logic [W-1:0]  pcplus4W,
  output logic [W-1:0]  immextW,
  output logic [4:0]    rdW,
  output logic          regwriteW,
  output logic [1:0]    resultsrcW,
  output logic          validW,
  output logic [CW-1:0] retiredW
);

  logic [1:0]   off;
  logic [7:0]   bsel;
  logic [15:0]  hsel;
  logic [W-1:0] ldext;
  logic         is_lb;
  logic         is_lh;
  logic         is_lbu;
  logic         is_lhu;

  assign off    = aluresultM[1:0];
  assign is_lb  = (funct3M == 3'b000);
  assign is_lh  = (funct3M == 3'b001);
  assign is_lbu = (funct3M == 3'b100);
  assign is_lhu = (funct3M == 3'b101);

  always_comb begin
    bsel = readdataM[7:0];
    case (off)
      2'd1:    bsel = readdataM[15:8];
      2'd2:    bsel = readdataM[23:16];
      2'd3:    bsel = readdataM[31:24];
      default: bsel = readdataM[7:0];
    endcase
  end

  // off[0] is ignored: misaligned halves are not trapped
  assign hsel = off[1] ? readdataM[31:16]
                       : readdataM[15:0];

  always_comb begin
    ldext = readdataM;
    unique case (1'b1)
      is_lb:   ldext = {{(W-8){bsel[7]}}, bsel};
      is_lbu:  ldext = {{(W-8){1'b0}}, bsel};
      is_lh:   ldext = {{(W-16){hsel[15]}}, hsel};
      is_lhu:  ldext = {{(W-16){1'b0}}, hsel};
      default: ldext = readdataM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aluresultW <= '0;
      readdataW  <= '0;
      pcplus4W   <= '0;
      immextW    <= '0;
      rdW        <= '0;
      regwriteW  <= 1'b0;
      resultsrcW <= '0;
      validW     <= 1'b0;
      retiredW   <= '0;
    end else if (flushW) begin
      aluresultW <= '0;
      readdataW  <= '0;
      pcplus4W   <= '0;
      immextW    <= '0;
      rdW        <= '0;
      regwriteW  <= 1'b0;
      resultsrcW <= '0;
      validW     <= 1'b0;
    end else if (!stallW) begin
      aluresultW <= aluresultM;
      readdataW  <= ldext;
      pcplus4W   <= pcplus4M;
      immextW    <= immextM;
      rdW        <= rdM;
      regwriteW  <= regwriteM & validM
                    & (rdM != 5'd0);
      resultsrcW <= resultsrcM;
      validW     <= validM;
      if (validM)
        retiredW <= retiredW + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_reg_mw.sv
// Directed self-checking bench for pipe_reg_mw,
// with a second 4-bit-counter instance for wrap.
module tb_pipe_reg_mw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallW;
  logic        flushW;
  logic        validM;
  logic [31:0] aluresultM;
  logic [31:0] readdataM;
  logic [31:0] pcplus4M;
  logic [31:0] immextM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic        regwriteM;
  logic [1:0]  resultsrcM;

  logic [31:0] aluresultW, readdataW;
  logic [31:0] pcplus4W, immextW;
  logic [4:0]  rdW;
  logic        regwriteW, validW;
  logic [1:0]  resultsrcW;
  logic [31:0] retiredW;

  logic [31:0] a4, r4d, p4, i4;
  logic [4:0]  rd4;
  logic        rw4, v4;
  logic [1:0]  rs4;
  logic [3:0]  ret4;

  int nchk = 0;
  int nerr = 0;
  int expret;

  always #5 clk = ~clk;

  pipe_reg_mw #(.W(32), .CW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .stallW(stallW), .flushW(flushW),
    .validM(validM),
    .aluresultM(aluresultM),
    .readdataM(readdataM),
    .pcplus4M(pcplus4M),
    .immextM(immextM),
    .funct3M(funct3M), .rdM(rdM),
    .regwriteM(regwriteM),
    .resultsrcM(resultsrcM),
    .aluresultW(aluresultW),
    .readdataW(readdataW),
    .pcplus4W(pcplus4W),
    .immextW(immextW),
    .rdW(rdW), .regwriteW(regwriteW),
    .resultsrcW(resultsrcW),
    .validW(validW),
    .retiredW(retiredW)
  );

  pipe_reg_mw #(.W(32), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .stallW(stallW), .flushW(flushW),
    .validM(validM),
    .aluresultM(aluresultM),
    .readdataM(readdataM),
    .pcplus4M(pcplus4M),
    .immextM(immextM),
    .funct3M(funct3M), .rdM(rdM),
    .regwriteM(regwriteM),
    .resultsrcM(resultsrcM),
    .aluresultW(a4), .readdataW(r4d),
    .pcplus4W(p4), .immextW(i4),
    .rdW(rd4), .regwriteW(rw4),
    .resultsrcW(rs4), .validW(v4),
    .retiredW(ret4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] alu,
                       input logic [31:0] rdat,
                       input logic [2:0] f3,
                       input logic [4:0] rd,
                       input logic rw,
                       input logic [1:0] rs);
    validM     = v;
    aluresultM = alu;
    readdataM  = rdat;
    pcplus4M   = alu + 32'h100;
    immextM    = alu ^ 32'hA5A5_0000;
    funct3M    = f3;
    rdM        = rd;
    regwriteM  = rw;
    resultsrcM = rs;
  endtask

  task automatic randin();
    drive($urandom_range(1, 0), $urandom,
          $urandom, 3'($urandom), 5'($urandom),
          $urandom_range(1, 0), 2'($urandom));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".alu"}, aluresultW, 0);
    chk({tag, ".rdat"}, readdataW, 0);
    chk({tag, ".pc4"}, pcplus4W, 0);
    chk({tag, ".imm"}, immextW, 0);
    chk({tag, ".rd"}, {27'b0, rdW}, 0);
    chk({tag, ".rw"}, {31'b0, regwriteW}, 0);
    chk({tag, ".rs"}, {30'b0, resultsrcW}, 0);
    chk({tag, ".v"}, {31'b0, validW}, 0);
    chk({tag, ".ret"}, retiredW, 0);
    chk({tag, ".ret4"}, {28'b0, ret4}, 0);
  endtask

  task automatic ldchk(input string tag,
                       input logic [2:0] f3,
                       input logic [1:0] off,
                       input logic [31:0] exp);
    drive(1'b1, {30'h40, off}, 32'h80F0_7F11,
          f3, 5'd7, 1'b1, 2'b01);
    tick();
    expret++;
    chk(tag, readdataW, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    stallW = 1'b0;
    flushW = 1'b0;
    randin();
    tick();
    randin();
    stallW = 1'($urandom);
    flushW = 1'($urandom);
    tick();
    chk_zero("reset");

    rst_n  = 1'b1;
    stallW = 1'b0;
    flushW = 1'b0;
    expret = 0;
    ldchk("lb3",  3'b000, 2'd3, 32'hFFFF_FF80);
    ldchk("lbu3", 3'b100, 2'd3, 32'h0000_0080);
    ldchk("lh2",  3'b001, 2'd2, 32'hFFFF_80F0);
    ldchk("lhu2", 3'b101, 2'd2, 32'h0000_80F0);
    ldchk("lh1",  3'b001, 2'd1, 32'h0000_7F11);
    ldchk("lw",   3'b010, 2'd0, 32'h80F0_7F11);
    ldchk("lb0",  3'b000, 2'd0, 32'h0000_0011);
    ldchk("lbu1", 3'b100, 2'd1, 32'h0000_007F);
    ldchk("lb2",  3'b000, 2'd2, 32'hFFFF_FFF0);
    ldchk("lh3",  3'b001, 2'd3, 32'hFFFF_80F0);
    ldchk("lhu0", 3'b101, 2'd0, 32'h0000_7F11);
    ldchk("f011", 3'b011, 2'd3, 32'h80F0_7F11);
    chk("ld.alu", aluresultW, 32'h0000_0103);
    chk("ld.pc4", pcplus4W, 32'h0000_0203);
    chk("ld.imm", immextW, 32'hA5A5_0103);
    chk("ld.rd", {27'b0, rdW}, 7);
    chk("ld.rw", {31'b0, regwriteW}, 1);
    chk("ld.rs", {30'b0, resultsrcW}, 1);
    chk("ld.v", {31'b0, validW}, 1);
    chk("ld.ret", retiredW, expret);

    drive(1'b1, 32'h1234, 32'h0, 3'b010,
          5'd3, 1'b1, 2'b00);
    tick();
    expret++;
    chk("st.load", aluresultW, 32'h1234);
    stallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h9000 + i, 32'hFFFF, 3'b000,
            5'd9, 1'b1, 2'b11);
      tick();
      chk("st.alu", aluresultW, 32'h1234);
      chk("st.ret", retiredW, expret);
    end
    flushW = 1'b1;
    tick();
    chk("fl.v", {31'b0, validW}, 0);
    chk("fl.rw", {31'b0, regwriteW}, 0);
    chk("fl.alu", aluresultW, 0);
    chk("fl.pc4", pcplus4W, 0);
    chk("fl.ret", retiredW, expret);
    stallW = 1'b0;
    flushW = 1'b0;

    drive(1'b1, 32'h55, 32'h0, 3'b010,
          5'd0, 1'b1, 2'b00);
    tick();
    expret++;
    chk("x0.rw", {31'b0, regwriteW}, 0);
    chk("x0.v", {31'b0, validW}, 1);
    drive(1'b0, 32'h66, 32'h0, 3'b010,
          5'd5, 1'b1, 2'b00);
    tick();
    chk("inv.rw", {31'b0, regwriteW}, 0);
    chk("inv.v", {31'b0, validW}, 0);
    chk("inv.rd", {27'b0, rdW}, 5);
    chk("inv.ret", retiredW, expret);
    drive(1'b1, 32'h77, 32'h0, 3'b010,
          5'd5, 1'b1, 2'b00);
    tick();
    expret++;
    chk("wr.rw", {31'b0, regwriteW}, 1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, i, 32'h0, 3'b010,
            5'd1, 1'b1, 2'b00);
      tick();
      if (i >= 15)
        chk("wrap4", {28'b0, ret4}, i % 16);
    end
    chk("wrap32", retiredW, 16);
    drive(1'b0, 32'h1, 32'h0, 3'b010,
          5'd1, 1'b1, 2'b00);
    tick();
    chk("nov.ret4", {28'b0, ret4}, 0);
    drive(1'b1, 32'h2, 32'h0, 3'b010,
          5'd1, 1'b1, 2'b00);
    flushW = 1'b1;
    tick();
    chk("flu.ret4", {28'b0, ret4}, 0);
    chk("flu.ret", retiredW, 16);
    flushW = 1'b0;

    drive(1'b1, 32'hABCD, 32'hFFFF_FFFF,
          3'b000, 5'd4, 1'b1, 2'b11);
    tick();
    chk("pre.alu", aluresultW, 32'hABCD);
    rst_n  = 1'b0;
    stallW = 1'b1;
    flushW = 1'b1;
    tick();
    chk_zero("mrst");

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
